// File: rtl/rom_dl_bridge.sv
// ROM download bridge: buffers data_io bytes in a FIFO and replays them as toggle req/ack writes
// on two SDRAM ports, then signals rom_loaded. Define ROM_DL_CHECKSUM_EN to add csum/csum_valid.
module rom_dl_bridge #(
    parameter int          DEPTH    = 8,
    parameter logic [24:0] GFX_BASE = 25'h07000,
    parameter logic [16:0] DL_LIMIT = 17'h1C200
) (
    input  logic        clk_sys,
    input  logic        res_n,
    input  logic        ioctl_downl,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        user_reset,
    output logic        port1_req,
    input  logic        port1_ack,
    output logic [22:0] port1_a,
    output logic [1:0]  port1_ds,
    output logic [15:0] port1_d,
    output logic        port2_req,
    input  logic        port2_ack,
    output logic [22:0] port2_a,
    output logic [1:0]  port2_ds,
    output logic [15:0] port2_d,
    output logic        port_we,
    output logic        dl_wr,
    output logic [16:0] dl_addr,
    output logic [7:0]  dl_data,
    output logic        rom_loaded,
    output logic        core_reset,
    output logic        ovf
`ifdef ROM_DL_CHECKSUM_EN
    ,
    output logic [15:0] csum,
    output logic        csum_valid
`endif
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [24:0] fifo_addr [0:DEPTH-1];
    logic [7:0]  fifo_data [0:DEPTH-1];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    logic [1:0]  state;
    logic        gfx_sel;
    logic        wr_prev;
    logic        downl_prev;
    logic        ack1_meta;
    logic        ack1_s;
    logic        ack2_meta;
    logic        ack2_s;
    logic        done_armed;

    logic        capture;
    logic        dl_rise;
    logic        dl_fall;
    logic        empty;
    logic        full;
    logic        acks_match;
    logic        pop;
    logic        push;
    logic [24:0] head_addr;
    logic [7:0]  head_data;
    logic        head_gfx;
    logic [23:0] gfx_g;

    assign capture    = ioctl_downl && ioctl_wr && !wr_prev;
    assign dl_rise    = ioctl_downl && !downl_prev;
    assign dl_fall    = !ioctl_downl && downl_prev;
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign acks_match = (ack1_s == port1_req) && (ack2_s == port2_req);
    assign pop        = (state == S_IDLE) && !empty && acks_match;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    assign push       = capture && (!full || pop);

    assign head_addr  = fifo_addr[rd_ptr[AW-1:0]];
    assign head_data  = fifo_data[rd_ptr[AW-1:0]];
    assign head_gfx   = (head_addr >= GFX_BASE);
    assign gfx_g      = head_addr[23:0] - GFX_BASE[23:0];

    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_addr[wr_ptr[AW-1:0]] <= ioctl_addr;
            fifo_data[wr_ptr[AW-1:0]] <= ioctl_dout;
        end
    end

    always_ff @(posedge clk_sys or negedge res_n) begin
        if (!res_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            state      <= S_IDLE;
            gfx_sel    <= 1'b0;
            wr_prev    <= 1'b0;
            downl_prev <= 1'b0;
            ack1_meta  <= 1'b0;
            ack1_s     <= 1'b0;
            ack2_meta  <= 1'b0;
            ack2_s     <= 1'b0;
            done_armed <= 1'b0;
            port1_req  <= 1'b0;
            port1_a    <= '0;
            port1_ds   <= '0;
            port1_d    <= '0;
            port2_req  <= 1'b0;
            port2_a    <= '0;
            port2_ds   <= '0;
            port2_d    <= '0;
            port_we    <= 1'b0;
            dl_wr      <= 1'b0;
            dl_addr    <= '0;
            dl_data    <= '0;
            rom_loaded <= 1'b0;
            core_reset <= 1'b1;
            ovf        <= 1'b0;
        end else begin
            wr_prev    <= ioctl_wr;
            downl_prev <= ioctl_downl;
            port_we    <= ioctl_downl;
            ack1_meta  <= port1_ack;
            ack1_s     <= ack1_meta;
            ack2_meta  <= port2_ack;
            ack2_s     <= ack2_meta;

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (capture && full && !pop) ovf <= 1'b1;

            dl_wr <= capture && ({8'd0, DL_LIMIT} > ioctl_addr);
            if (capture) begin
                dl_addr <= ioctl_addr[16:0];
                dl_data <= ioctl_dout;
            end

            case (state)
                S_IDLE: begin
                    if (pop) begin
                        port1_a  <= head_addr[23:1];
                        port1_ds <= {head_addr[0], ~head_addr[0]};
                        port1_d  <= {head_data, head_data};
                        if (head_gfx) begin
                            port2_a  <= {gfx_g[23:15], gfx_g[13:0]};
                            port2_ds <= {gfx_g[14], ~gfx_g[14]};
                            port2_d  <= {head_data, head_data};
                        end
                        gfx_sel <= head_gfx;
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    port1_req <= ~port1_req;
                    if (gfx_sel) port2_req <= ~port2_req;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // The untoggled port already matches, so one test covers both cases.
                    if (acks_match) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            if (dl_rise) begin
                done_armed <= 1'b0;
                rom_loaded <= 1'b0;
            end else begin
                if (dl_fall) done_armed <= 1'b1;
                if (done_armed && empty && (state == S_IDLE) && acks_match) rom_loaded <= 1'b1;
            end

            core_reset <= user_reset | ~rom_loaded;
        end
    end

`ifdef ROM_DL_CHECKSUM_EN
    always_ff @(posedge clk_sys or negedge res_n) begin
        if (!res_n) begin
            csum <= '0;
        end else if (dl_rise) begin
            csum <= capture ? {8'd0, ioctl_dout} : 16'd0;
        end else if (capture) begin
            csum <= csum + {8'd0, ioctl_dout};
        end
    end

    assign csum_valid = rom_loaded;
`endif

endmodule

// File: tb/tb_rom_dl_bridge.sv
// Directed bench for rom_dl_bridge with a toggle-ack SDRAM responder model and transaction monitor.
module tb_rom_dl_bridge;
    logic        clk_sys = 1'b0;
    logic        res_n = 1'b1;
    logic        ioctl_downl = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        user_reset = 1'b0;
    logic        port1_req, port2_req;
    logic        port1_ack, port2_ack;
    logic [22:0] port1_a, port2_a;
    logic [1:0]  port1_ds, port2_ds;
    logic [15:0] port1_d, port2_d;
    logic        port_we, dl_wr, rom_loaded, core_reset, ovf;
    logic [16:0] dl_addr;
    logic [7:0]  dl_data;
`ifdef ROM_DL_CHECKSUM_EN
    logic [15:0] csum;
    logic        csum_valid;
`endif

    int checks = 0;
    int fails = 0;
    int cyc = 0;

    rom_dl_bridge dut (
        .clk_sys(clk_sys), .res_n(res_n), .ioctl_downl(ioctl_downl), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .user_reset(user_reset),
        .port1_req(port1_req), .port1_ack(port1_ack), .port1_a(port1_a), .port1_ds(port1_ds), .port1_d(port1_d),
        .port2_req(port2_req), .port2_ack(port2_ack), .port2_a(port2_a), .port2_ds(port2_ds), .port2_d(port2_d),
        .port_we(port_we), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
        .rom_loaded(rom_loaded), .core_reset(core_reset), .ovf(ovf)
`ifdef ROM_DL_CHECKSUM_EN
        , .csum(csum), .csum_valid(csum_valid)
`endif
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    // SDRAM-side responder: echoes req onto ack after a programmable delay unless stalled.
    logic stall = 1'b0;
    int ack1_delay = 6, ack2_delay = 6;
    int cnt1 = 0, cnt2 = 0, ack1_cnt = 0, ack2_cnt = 0, ack2_cyc = 0;

    always @(posedge clk_sys or negedge res_n) begin
        if (!res_n) begin
            port1_ack <= 1'b0; port2_ack <= 1'b0; cnt1 <= 0; cnt2 <= 0;
        end else begin
            if (!stall && port1_req != port1_ack) begin
                if (cnt1 + 1 >= ack1_delay) begin
                    port1_ack <= port1_req; cnt1 <= 0; ack1_cnt <= ack1_cnt + 1;
                end else cnt1 <= cnt1 + 1;
            end
            if (!stall && port2_req != port2_ack) begin
                if (cnt2 + 1 >= ack2_delay) begin
                    port2_ack <= port2_req; cnt2 <= 0; ack2_cnt <= ack2_cnt + 1; ack2_cyc <= cyc;
                end else cnt2 <= cnt2 + 1;
            end
        end
    end

    // Transaction monitor: records port outputs on every req toggle and every dl_wr pulse.
    logic p1_prev = 1'b0, p2_prev = 1'b0;
    logic [22:0] q1_a[$], q2_a[$];
    logic [1:0]  q1_ds[$], q2_ds[$];
    logic [15:0] q1_d[$], q2_d[$];
    int          q1_t[$];
    int          dl_cnt = 0;
    logic [16:0] dl_last_addr = '0;
    logic [7:0]  dl_last_data = '0;

    always @(negedge clk_sys) begin
        if (res_n) begin
            if (port1_req !== p1_prev) begin
                q1_a.push_back(port1_a); q1_ds.push_back(port1_ds); q1_d.push_back(port1_d); q1_t.push_back(cyc);
                $display("[%0d] port1 txn a=%06h ds=%b d=%04h", cyc, port1_a, port1_ds, port1_d);
            end
            if (port2_req !== p2_prev) begin
                q2_a.push_back(port2_a); q2_ds.push_back(port2_ds); q2_d.push_back(port2_d);
                $display("[%0d] port2 txn a=%06h ds=%b d=%04h", cyc, port2_a, port2_ds, port2_d);
            end
            if (dl_wr === 1'b1) begin
                dl_cnt <= dl_cnt + 1; dl_last_addr <= dl_addr; dl_last_data <= dl_data;
            end
        end
        p1_prev <= port1_req;
        p2_prev <= port2_req;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input int hold, input int gap);
        @(negedge clk_sys);
        ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
        repeat (hold) @(negedge clk_sys);
        ioctl_wr = 1'b0;
        repeat (gap) @(negedge clk_sys);
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_tx1(input int n, input int budget, input string name);
        int k = 0;
        while (q1_a.size() < n && k < budget) begin
            @(posedge clk_sys); #1; k++;
        end
        checks++;
        if (q1_a.size() < n) begin
            fails++; $display("FAIL %s_timeout: got %0d port1 txns required %0d", name, q1_a.size(), n);
        end
    endtask

    task automatic test_reset();
        #1 res_n = 1'b0;
        repeat (3) @(negedge clk_sys);
        checks++; if (port1_req !== 1'b0) begin fails++; $display("FAIL reset_port1_req: got %b required 0", port1_req); end
        checks++; if (port2_req !== 1'b0) begin fails++; $display("FAIL reset_port2_req: got %b required 0", port2_req); end
        checks++; if (core_reset !== 1'b1) begin fails++; $display("FAIL reset_core_reset: got %b required 1", core_reset); end
        checks++; if (rom_loaded !== 1'b0) begin fails++; $display("FAIL reset_rom_loaded: got %b required 0", rom_loaded); end
        checks++; if (dl_wr !== 1'b0) begin fails++; $display("FAIL reset_dl_wr: got %b required 0", dl_wr); end
        checks++; if (ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b required 0", ovf); end
        checks++; if (port_we !== 1'b0) begin fails++; $display("FAIL reset_port_we: got %b required 0", port_we); end
        res_n = 1'b1;
        repeat (2) @(negedge clk_sys);
    endtask

    task automatic test_port1();
        int b1, b2;
        ioctl_downl = 1'b1; ack1_delay = 6; ack2_delay = 6;
        b1 = q1_a.size(); b2 = q2_a.size();
        repeat (2) @(negedge clk_sys);
        checks++; if (port_we !== 1'b1) begin fails++; $display("FAIL p1_port_we: got %b required 1", port_we); end
        ioctl_addr = 25'h00003; ioctl_dout = 8'h5A; ioctl_wr = 1'b1;
        @(negedge clk_sys);
        checks++; if (dl_wr !== 1'b1) begin fails++; $display("FAIL p1_dl_wr_pulse: got %b required 1", dl_wr); end
        checks++; if (dl_addr !== 17'h00003) begin fails++; $display("FAIL p1_dl_addr: got %h required 00003", dl_addr); end
        checks++; if (dl_data !== 8'h5A) begin fails++; $display("FAIL p1_dl_data: got %h required 5a", dl_data); end
        @(negedge clk_sys);
        checks++; if (dl_wr !== 1'b0) begin fails++; $display("FAIL p1_dl_wr_width: got %b required 0", dl_wr); end
        ioctl_wr = 1'b0;
        wait_tx1(b1 + 1, 40, "p1");
        settle(30);
        checks++; if (q1_a.size() != b1 + 1) begin fails++; $display("FAIL p1_count: got %0d required %0d", q1_a.size(), b1 + 1); end
        checks++; if (q1_a[b1] !== 23'h000001) begin fails++; $display("FAIL p1_a: got %h required 000001", q1_a[b1]); end
        checks++; if (q1_ds[b1] !== 2'b10) begin fails++; $display("FAIL p1_ds: got %b required 10", q1_ds[b1]); end
        checks++; if (q1_d[b1] !== 16'h5A5A) begin fails++; $display("FAIL p1_d: got %h required 5a5a", q1_d[b1]); end
        checks++; if (q2_a.size() != b2) begin fails++; $display("FAIL p1_no_port2: got %0d port2 txns required %0d", q2_a.size(), b2); end
    endtask

    task automatic test_gfx();
        int b1, b2;
        ack1_delay = 3; ack2_delay = 10;
        b1 = q1_a.size(); b2 = q2_a.size();
        send_byte(25'h0B123, 8'hC3, 1, 2);
        send_byte(25'h00020, 8'h44, 1, 2);
        wait_tx1(b1 + 2, 80, "gfx");
        settle(30);
        checks++; if (q1_a[b1] !== 23'h005891) begin fails++; $display("FAIL gfx_p1_a: got %h required 005891", q1_a[b1]); end
        checks++; if (q1_d[b1] !== 16'hC3C3) begin fails++; $display("FAIL gfx_p1_d: got %h required c3c3", q1_d[b1]); end
        checks++; if (q2_a.size() != b2 + 1) begin fails++; $display("FAIL gfx_p2_count: got %0d required %0d", q2_a.size(), b2 + 1); end
        checks++; if (q2_a[b2] !== 23'h000123) begin fails++; $display("FAIL gfx_p2_a: got %h required 000123", q2_a[b2]); end
        checks++; if (q2_ds[b2] !== 2'b10) begin fails++; $display("FAIL gfx_p2_ds: got %b required 10", q2_ds[b2]); end
        checks++; if (q2_d[b2] !== 16'hC3C3) begin fails++; $display("FAIL gfx_p2_d: got %h required c3c3", q2_d[b2]); end
        checks++; if (q1_t[b1 + 1] <= ack2_cyc) begin fails++; $display("FAIL gfx_waits_port2: next issue cycle %0d required after ack2 cycle %0d", q1_t[b1 + 1], ack2_cyc); end
        checks++; if (q1_a[b1 + 1] !== 23'h000010 || q1_ds[b1 + 1] !== 2'b01) begin
            fails++; $display("FAIL gfx_next_p1: got a=%h ds=%b required a=000010 ds=01", q1_a[b1 + 1], q1_ds[b1 + 1]);
        end
    endtask

    task automatic test_held_limit();
        int b1, b2, bd;
        ack1_delay = 4; ack2_delay = 4;
        b1 = q1_a.size(); b2 = q2_a.size(); bd = dl_cnt;
        send_byte(25'h1C1FF, 8'h11, 5, 3);
        send_byte(25'h1C200, 8'h22, 5, 3);
        wait_tx1(b1 + 2, 80, "held");
        settle(30);
        checks++; if (q1_a.size() != b1 + 2) begin fails++; $display("FAIL held_count: got %0d required %0d", q1_a.size(), b1 + 2); end
        checks++; if (dl_cnt != bd + 1) begin fails++; $display("FAIL limit_dl_count: got %0d required %0d", dl_cnt, bd + 1); end
        checks++; if (dl_last_addr !== 17'h1C1FF || dl_last_data !== 8'h11) begin
            fails++; $display("FAIL limit_dl_last: got %h/%h required 1c1ff/11", dl_last_addr, dl_last_data);
        end
        checks++; if (q2_a[b2] !== 23'h0091FF) begin fails++; $display("FAIL held_p2_a0: got %h required 0091ff", q2_a[b2]); end
        checks++; if (q2_a[b2 + 1] !== 23'h009200) begin fails++; $display("FAIL held_p2_a1: got %h required 009200", q2_a[b2 + 1]); end
        checks++; if (q1_a[b1 + 1] !== 23'h00E100) begin fails++; $display("FAIL held_p1_a1: got %h required 00e100", q1_a[b1 + 1]); end
    endtask

    task automatic test_overflow();
        int b1;
        logic [7:0] dv;
        ack1_delay = 2; ack2_delay = 2; stall = 1'b1;
        b1 = q1_a.size();
        for (int i = 0; i < 9; i++) begin
            dv = 8'hA0 + 8'(i);
            send_byte(25'h00100 + 25'(i), dv, 1, 2);
        end
        settle(2);
        checks++; if (ovf !== 1'b0) begin fails++; $display("FAIL ovf_full_no_drop: got %b required 0", ovf); end
        send_byte(25'h00109, 8'hA9, 1, 2);
        settle(2);
        checks++; if (ovf !== 1'b1) begin fails++; $display("FAIL ovf_set: got %b required 1", ovf); end
        checks++; if (q1_a.size() != b1 + 1) begin fails++; $display("FAIL ovf_in_flight: got %0d required %0d", q1_a.size(), b1 + 1); end
        stall = 1'b0;
        wait_tx1(b1 + 9, 300, "ovf");
        settle(40);
        checks++; if (q1_a.size() != b1 + 9) begin fails++; $display("FAIL ovf_drained: got %0d required %0d", q1_a.size(), b1 + 9); end
        for (int i = 0; i < 9; i++) begin
            dv = 8'hA0 + 8'(i);
            checks++; if (q1_d[b1 + i] !== {dv, dv}) begin fails++; $display("FAIL ovf_data%0d: got %h required %h", i, q1_d[b1 + i], {dv, dv}); end
        end
        checks++; if (ovf !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b required 1", ovf); end
    endtask

    task automatic test_completion();
        int ba, b1, k;
        ioctl_downl = 1'b0;
        repeat (10) @(negedge clk_sys);
        checks++; if (rom_loaded !== 1'b1) begin fails++; $display("FAIL cmp_idle_loaded: got %b required 1", rom_loaded); end
        checks++; if (core_reset !== 1'b0) begin fails++; $display("FAIL cmp_core_released: got %b required 0", core_reset); end
        user_reset = 1'b1;
        repeat (2) @(negedge clk_sys);
        checks++; if (core_reset !== 1'b1) begin fails++; $display("FAIL cmp_user_reset: got %b required 1", core_reset); end
        user_reset = 1'b0;
        ioctl_downl = 1'b1;
        repeat (3) @(negedge clk_sys);
        checks++; if (rom_loaded !== 1'b0 || core_reset !== 1'b1) begin
            fails++; $display("FAIL cmp_rise_clears: got loaded=%b core_reset=%b required 0/1", rom_loaded, core_reset);
        end
        stall = 1'b1; ack1_delay = 3; ba = ack1_cnt; b1 = q1_a.size();
        send_byte(25'h00200, 8'hFF, 1, 2);
        send_byte(25'h00201, 8'h02, 1, 2);
        send_byte(25'h00202, 8'h00, 1, 2);
        send_byte(25'h00203, 8'h00, 1, 2);
        ioctl_downl = 1'b0;
        repeat (10) @(negedge clk_sys);
        checks++; if (rom_loaded !== 1'b0) begin fails++; $display("FAIL cmp_early_loaded: got %b required 0", rom_loaded); end
        stall = 1'b0;
        k = 0;
        while (rom_loaded !== 1'b1 && k < 200) begin @(negedge clk_sys); k++; end
        checks++; if (rom_loaded !== 1'b1) begin fails++; $display("FAIL cmp_loaded_timeout: got %b required 1", rom_loaded); end
        checks++; if (ack1_cnt - ba != 4) begin fails++; $display("FAIL cmp_acks_before_loaded: got %0d acks required 4", ack1_cnt - ba); end
        checks++; if (core_reset !== 1'b1) begin fails++; $display("FAIL cmp_core_reset_lag: got %b required 1", core_reset); end
        @(negedge clk_sys);
        checks++; if (core_reset !== 1'b0) begin fails++; $display("FAIL cmp_core_reset_fall: got %b required 0", core_reset); end
        send_byte(25'h00300, 8'h55, 1, 2);
        settle(20);
        checks++; if (q1_a.size() != b1 + 4) begin fails++; $display("FAIL cmp_no_capture_idle: got %0d required %0d", q1_a.size(), b1 + 4); end
`ifdef ROM_DL_CHECKSUM_EN
        checks++; if (csum !== 16'h0101) begin fails++; $display("FAIL cmp_csum: got %h required 0101", csum); end
        checks++; if (csum_valid !== 1'b1) begin fails++; $display("FAIL cmp_csum_valid: got %b required 1", csum_valid); end
`endif
    endtask

    task automatic test_reset_mid();
        int b1;
        ioctl_downl = 1'b1; stall = 1'b1; ack1_delay = 4;
        send_byte(25'h00300, 8'h31, 1, 2);
        send_byte(25'h00301, 8'h32, 1, 2);
        send_byte(25'h00302, 8'h33, 1, 2);
        @(negedge clk_sys);
        res_n = 1'b0;
        #1;
        checks++; if (port1_req !== 1'b0 || port2_req !== 1'b0) begin
            fails++; $display("FAIL mid_reset_reqs: got %b/%b required 0/0", port1_req, port2_req);
        end
        checks++; if (core_reset !== 1'b1 || rom_loaded !== 1'b0) begin
            fails++; $display("FAIL mid_reset_core: got core_reset=%b loaded=%b required 1/0", core_reset, rom_loaded);
        end
        checks++; if (ovf !== 1'b0) begin fails++; $display("FAIL mid_reset_ovf: got %b required 0", ovf); end
        repeat (3) @(negedge clk_sys);
        res_n = 1'b1; stall = 1'b0;
        b1 = q1_a.size();
        repeat (3) @(negedge clk_sys);
        send_byte(25'h00010, 8'h77, 1, 2);
        wait_tx1(b1 + 1, 60, "mid");
        settle(60);
        checks++; if (q1_a.size() != b1 + 1) begin fails++; $display("FAIL mid_fifo_discarded: got %0d txns required %0d", q1_a.size(), b1 + 1); end
        checks++; if (q1_a[b1] !== 23'h000008 || q1_ds[b1] !== 2'b01 || q1_d[b1] !== 16'h7777) begin
            fails++; $display("FAIL mid_first_byte: got a=%h ds=%b d=%h required 000008/01/7777", q1_a[b1], q1_ds[b1], q1_d[b1]);
        end
    endtask

    initial begin
        test_reset();
        test_port1();
        test_gfx();
        test_held_limit();
        test_overflow();
        test_completion();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
